i2c_slave_regfile: RTL

//  Parametrised I2C target with an addressable 8-bit register file and an auto-incrementing pointer.

---
 rtl/i2c_slave_regfile.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C target with a pointer-addressed 8-bit register file; bus writes commit one clk after the detected 8th SCL fall, no clock stretching.
// Optional input glitch filter is enabled by defining I2C_SLV_FILTER_EN (adds FILTER_LEN clk latency on SCL/SDA).
module i2c_slave_regfile #(
  parameter logic [6:0] DEV_ADDR   = 7'h55,
  parameter int         NUM_REGS   = 32,
  parameter int         FILTER_LEN = 3,
  localparam int        PTR_W      = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             loc_we,
  input  logic [PTR_W-1:0] loc_waddr,
  input  logic [7:0]       loc_wdata,
  input  logic [PTR_W-1:0] loc_raddr,
  output logic [7:0]       loc_rdata,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  if (NUM_REGS < 2 || NUM_REGS > 256 || FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_param_chk
    $error("i2c_slave_regfile: parameter out of range");
  end

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_f, sda_f, scl_prev_q, sda_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef I2C_SLV_FILTER_EN
  // Index 1 = SCL, 0 = SDA; output follows only after FILTER_LEN consecutive differing samples.
  logic [1:0] filt_raw, filt_q;
  logic [3:0] fcnt_q [2];
  assign filt_raw = {scl_sync_q[1], sda_sync_q[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q    <= 2'b11;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (filt_raw[i] != filt_q[i]) begin
          if (fcnt_q[i] == 4'(FILTER_LEN - 1)) begin
            filt_q[i] <= filt_raw[i];
            fcnt_q[i] <= '0;
          end else begin
            fcnt_q[i] <= fcnt_q[i] + 4'd1;
          end
        end else begin
          fcnt_q[i] <= '0;
        end
      end
    end
  end
  assign scl_f = filt_q[1];
  assign sda_f = filt_q[0];
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f &  scl_prev_q;
  assign start_det =  scl_f &  scl_prev_q &  sda_prev_q & ~sda_f;
  assign stop_det  =  scl_f &  scl_prev_q & ~sda_prev_q &  sda_f;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       sh_q, sh_d, tx_q, tx_d;
  logic             rw_q, rw_d, mack_q, mack_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic             wr_valid_q, commit;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, wr_addr_q;
  logic [7:0]       wr_data_q;
  logic [7:0]       regs_q [NUM_REGS];

  logic byte_done, addr_hit, ptr_ok;
  assign byte_done = (cnt_q == 4'd8);
  assign addr_hit  = (sh_q[7:1] == DEV_ADDR);
  assign ptr_ok    = ({1'b0, sh_q} < 9'(NUM_REGS));
  assign ptr_inc   = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else if (scl_fall) begin
      case (state_q)
        ADDR:               if (byte_done) state_d = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:           state_d = rw_q ? RDATA : PTR;
        PTR:                if (byte_done) state_d = ptr_ok ? PTR_ACK : WAIT_STOP;
        PTR_ACK, WDATA_ACK: state_d = WDATA;
        WDATA:              if (byte_done) state_d = WDATA_ACK;
        RDATA:              if (cnt_q == 4'd7) state_d = RDATA_ACK;
        RDATA_ACK:          state_d = mack_q ? WAIT_STOP : RDATA;
        default:            state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    rw_d     = rw_q;
    mack_d   = mack_q;
    ptr_d    = ptr_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    commit   = 1'b0;
    if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end else if (start_det) begin
      sda_oe_d = 1'b0;
      cnt_d    = '0;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          sh_d  = {sh_q[6:0], sda_f};
          cnt_d = cnt_q + 4'd1;
        end
        RDATA_ACK: mack_d = sda_f;
        default:   ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ADDR: if (byte_done) begin
          rw_d     = sh_q[0];
          sda_oe_d = addr_hit;
          busy_d   = addr_hit;
          cnt_d    = '0;
        end
        ADDR_ACK: begin
          cnt_d    = '0;
          sda_oe_d = 1'b0;
          if (rw_q) begin
            tx_d     = regs_q[ptr_q];
            sda_oe_d = ~tx_d[7];
          end
        end
        PTR: if (byte_done) begin
          cnt_d    = '0;
          sda_oe_d = ptr_ok;
          if (ptr_ok) ptr_d = sh_q[PTR_W-1:0];
        end
        PTR_ACK, WDATA_ACK: begin
          sda_oe_d = 1'b0;
          cnt_d    = '0;
        end
        WDATA: if (byte_done) begin
          commit   = 1'b1;
          sda_oe_d = 1'b1;
          ptr_d    = ptr_inc;
          cnt_d    = '0;
        end
        RDATA: begin
          if (cnt_q == 4'd7) begin
            sda_oe_d = 1'b0;
          end else begin
            tx_d     = tx_q << 1;
            sda_oe_d = ~tx_d[7];
            cnt_d    = cnt_q + 4'd1;
          end
        end
        RDATA_ACK: begin
          ptr_d    = ptr_inc;
          cnt_d    = '0;
          sda_oe_d = 1'b0;
          if (!mack_q) begin
            tx_d     = regs_q[ptr_inc];
            sda_oe_d = ~tx_d[7];
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      cnt_q      <= '0;
      sh_q       <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b1;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= commit;
      if (commit) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= sh_q;
      end
    end
  end

  logic loc_wok, loc_rok;
  if (NUM_REGS == (1 << PTR_W)) begin : g_pow2
    assign loc_wok = 1'b1;
    assign loc_rok = 1'b1;
  end else begin : g_npow2
    assign loc_wok = ({1'b0, loc_waddr} < (PTR_W + 1)'(NUM_REGS));
    assign loc_rok = ({1'b0, loc_raddr} < (PTR_W + 1)'(NUM_REGS));
  end

  // Bus commit is written last so it overrides a same-cycle local write to the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: 8'h00};
    end else begin
      if (loc_we && loc_wok) regs_q[loc_waddr] <= loc_wdata;
      if (commit)            regs_q[ptr_q]     <= sh_q;
    end
  end

  assign loc_rdata = loc_rok ? regs_q[loc_raddr] : 8'h00;
  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
